// File: rtl/transpose_pkg.sv
// Shared types for the tile transpose datapath.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package transpose_pkg;

  // Life cycle of one ping-pong bank.
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // Per-tile output ordering, captured with row 0.
  localparam logic MODE_PASS      = 1'b0;
  localparam logic MODE_TRANSPOSE = 1'b1;

endpackage

// File: rtl/transpose_tile_buffer_if.sv
// Row-in / beat-out streaming bus of the tile transposer.
// Latency: none, wires only.
// Backpressure: in_ready and out_ready follow valid/ready semantics.
interface transpose_tile_buffer_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
);
  logic                        ctrl;
  logic                        in_valid;
  logic                        in_ready;
  logic [0:LANES-1][WIDTH-1:0] in_elements;
  logic                        out_valid;
  logic                        out_ready;
  logic [0:LANES-1][WIDTH-1:0] out_elements;
  logic                        out_last;

  // Producer/consumer side that drives rows and accepts beats.
  modport master (
    output ctrl, in_valid, in_elements, out_ready,
    input  in_ready, out_valid, out_elements, out_last
  );

  // Transposer side.
  modport slave (
    input  ctrl, in_valid, in_elements, out_ready,
    output in_ready, out_valid, out_elements, out_last
  );
endinterface

// File: rtl/transpose_bank.sv
// One tile bank: row-wide write port, row or column read mux, state and mode.
// Latency: write lands on the clock edge; read data is combinational from storage.
// Backpressure: none here, the caller only strobes wr_en/rd_en on real handshakes.
module transpose_bank
  import transpose_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int LANES = 4,
  localparam int CW    = $clog2(LANES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [CW-1:0]               wr_row,
  input  logic [0:LANES-1][WIDTH-1:0] wr_data,
  input  logic                        wr_mode,
  input  logic                        rd_en,
  input  logic [CW-1:0]               rd_idx,
  output bank_state_t                 state,
  output logic [0:LANES-1][WIDTH-1:0] rd_data
);

  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  // Storage indexed [row][column].
  logic [0:LANES-1][0:LANES-1][WIDTH-1:0] mem;
  logic                                   mode;

  // Row write; cleared on reset so an idle output bus reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  // Bank life cycle; a bank is never written and read in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      mode  <= MODE_PASS;
    end else if (wr_en) begin
      if (wr_row == '0) begin
        state <= FILLING;
        mode  <= wr_mode;
      end
      if (wr_row == LAST) begin
        state <= FULL;
      end
    end else if (rd_en) begin
      state <= (rd_idx == LAST) ? EMPTY : DRAINING;
    end
  end

  // Column rd_idx in transpose mode, row rd_idx in pass mode.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign rd_data[i] = (mode == MODE_TRANSPOSE) ? mem[i][rd_idx] : mem[rd_idx][i];
  end

endmodule

// File: rtl/transpose_tile_buffer.sv
// Ping-pong LANESxLANES tile transposer: rows in, columns (or rows) out.
// Latency: first output beat valid the cycle after the last row is accepted.
// Backpressure: in_ready low while the write bank is full; out_ready low holds the beat.
module transpose_tile_buffer
  import transpose_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int LANES = 4,
  localparam int CW    = $clog2(LANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  transpose_tile_buffer_if.slave bus
);

  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  logic          wp;
  logic          rp;
  logic [CW-1:0] wr;
  logic [CW-1:0] rd;

  bank_state_t                 st   [2];
  logic [0:LANES-1][WIDTH-1:0] rdat [2];

  logic in_ready_w;
  logic out_valid_w;
  logic in_hs;
  logic out_hs;

  assign in_ready_w  = rst && (st[wp] == EMPTY || st[wp] == FILLING);
  assign out_valid_w = (st[rp] == FULL) || (st[rp] == DRAINING);
  assign in_hs       = bus.in_valid && in_ready_w;
  assign out_hs      = out_valid_w && bus.out_ready;

  assign bus.in_ready     = in_ready_w;
  assign bus.out_valid    = out_valid_w;
  assign bus.out_last     = out_valid_w && (rd == LAST);
  assign bus.out_elements = rdat[rp];

  for (genvar g = 0; g < 2; g++) begin : g_bank
    transpose_bank #(
      .WIDTH (WIDTH),
      .LANES (LANES)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (in_hs && (wp == 1'(g))),
      .wr_row  (wr),
      .wr_data (bus.in_elements),
      .wr_mode (bus.ctrl),
      .rd_en   (out_hs && (rp == 1'(g))),
      .rd_idx  (rd),
      .state   (st[g]),
      .rd_data (rdat[g])
    );
  end

  // Write side: advance row, hand the bank over after the last row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr <= '0;
      wp <= 1'b0;
    end else if (in_hs) begin
      if (wr == LAST) begin
        wr <= '0;
        wp <= ~wp;
      end else begin
        wr <= wr + 1'b1;
      end
    end
  end

  // Read side: advance beat, move to the other bank after the last beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd <= '0;
      rp <= 1'b0;
    end else if (out_hs) begin
      if (rd == LAST) begin
        rd <= '0;
        rp <= ~rp;
      end else begin
        rd <= rd + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_transpose_tile_buffer.sv
// Directed and random checks of transpose_tile_buffer with WIDTH=8, LANES=4.
// Latency: inputs driven 1 time unit after the rising edge, outputs checked there.
// Backpressure: exercised by held out_ready and random valid/ready.
module tb_transpose_tile_buffer;

  typedef logic [31:0] tile_t [4];

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  transpose_tile_buffer_if #(.WIDTH(8), .LANES(4)) bus ();

  transpose_tile_buffer #(.WIDTH(8), .LANES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Element c of a beat sits in the top byte for c=0.
  function automatic logic [31:0] exp_beat(input tile_t t, input logic m, input int b);
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      res[31-8*i -: 8] = m ? t[i][31-8*b -: 8] : t[b][31-8*i -: 8];
    end
    return res;
  endfunction

  function automatic tile_t make_tile(input int t);
    tile_t r;
    for (int i = 0; i < 4; i++) begin
      r[i] = 32'h00010203 + 32'h10101010 * i + 32'h40404040 * t;
    end
    return r;
  endfunction

  tile_t       rows_v;
  logic [31:0] exp_t [4];
  tile_t       bt [3];
  logic        bm [3];
  tile_t       pa, pb;
  tile_t       cur_rows;
  logic        cur_mode;
  logic [32:0] exp_q [$];
  logic [32:0] e;

  initial begin
    rows_v = '{32'h00010203, 32'h10111213, 32'h20212223, 32'h30313233};
    exp_t  = '{32'h00102030, 32'h01112131, 32'h02122232, 32'h03132333};

    bus.ctrl        = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_elements = '0;
    bus.out_ready   = 1'b0;
    rst             = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_elements", bus.out_elements, 0);
    rst = 1'b1;
    #1;
    check("rst_release_in_ready", bus.in_ready, 1);
    tick();

    // Reset in the middle of a tile fill.
    for (int r = 0; r < 2; r++) begin
      bus.in_valid    = 1'b1;
      bus.in_elements = 32'h80808080 + r;
      bus.ctrl        = 1'b1;
      tick();
    end
    rst = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_elements", bus.out_elements, 0);
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    tick();

    // Transpose: ctrl high only on row 0.
    bus.out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      bus.in_valid    = 1'b1;
      bus.in_elements = rows_v[r];
      bus.ctrl        = (r == 0);
      check("tr_in_ready", bus.in_ready, 1);
      check("tr_no_early_out", bus.out_valid, 0);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      check("tr_out_valid", bus.out_valid, 1);
      check("tr_data", bus.out_elements, exp_t[b]);
      check("tr_last", bus.out_last, (b == 3) ? 1 : 0);
      tick();
    end
    check("tr_idle", bus.out_valid, 0);

    // Pass: ctrl low on row 0, high on later rows.
    for (int r = 0; r < 4; r++) begin
      bus.in_valid    = 1'b1;
      bus.in_elements = rows_v[r];
      bus.ctrl        = (r != 0);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      check("pass_out_valid", bus.out_valid, 1);
      check("pass_data", bus.out_elements, rows_v[b]);
      check("pass_last", bus.out_last, (b == 3) ? 1 : 0);
      tick();
    end
    check("pass_idle", bus.out_valid, 0);

    // Back-to-back: three tiles, no bubbles on either side.
    bm = '{1'b1, 1'b0, 1'b1};
    for (int t = 0; t < 3; t++) bt[t] = make_tile(t);
    for (int s = 0; s < 16; s++) begin
      if (s < 12) begin
        bus.in_valid    = 1'b1;
        bus.in_elements = bt[s/4][s%4];
        bus.ctrl        = (s % 4 == 0) ? bm[s/4] : ~bm[s/4];
        check("b2b_in_ready", bus.in_ready, 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (s >= 4) begin
        check("b2b_out_valid", bus.out_valid, 1);
        check("b2b_data", bus.out_elements, exp_beat(bt[(s-4)/4], bm[(s-4)/4], (s-4)%4));
        check("b2b_last", bus.out_last, ((s-4) % 4 == 3) ? 1 : 0);
      end
      tick();
    end
    check("b2b_idle", bus.out_valid, 0);

    // Backpressure: two tiles fill both banks, then drain.
    pa = make_tile(1);
    pb = make_tile(3);
    bus.out_ready = 1'b0;
    for (int s = 0; s < 8; s++) begin
      bus.in_valid    = 1'b1;
      bus.in_elements = (s < 4) ? pa[s%4] : pb[s%4];
      bus.ctrl        = (s % 4 == 0);
      check("bp_in_ready", bus.in_ready, 1);
      tick();
    end
    bus.in_valid = 1'b0;
    check("bp_full_in_ready", bus.in_ready, 0);
    for (int h = 0; h < 5; h++) begin
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_data", bus.out_elements, exp_beat(pa, 1'b1, 0));
      check("bp_hold_in_ready", bus.in_ready, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("bp_data", bus.out_elements, exp_beat((k < 4) ? pa : pb, 1'b1, k % 4));
      check("bp_last", bus.out_last, (k % 4 == 3) ? 1 : 0);
      if (k < 4) check("bp_drain_in_ready", bus.in_ready, 0);
      if (k == 4) check("bp_reopen_in_ready", bus.in_ready, 1);
      tick();
    end
    check("bp_idle", bus.out_valid, 0);

    // Random valid/ready against a scoreboard, 500 tiles.
    begin
      int  beats_in;
      int  tiles_out;
      int  in_row;
      int  cyc;
      logic hs_in;
      logic hs_out;
      beats_in  = 0;
      tiles_out = 0;
      in_row    = 0;
      hs_in     = 1'b0;
      bus.in_valid = 1'b0;
      for (cyc = 0; cyc < 20000 && tiles_out < 500; cyc++) begin
        if (hs_in || !bus.in_valid) begin
          if (beats_in < 2000 && $urandom_range(0, 3) != 0) begin
            bus.in_valid    = 1'b1;
            bus.in_elements = $urandom;
            bus.ctrl        = 1'($urandom_range(0, 1));
          end else begin
            bus.in_valid = 1'b0;
          end
        end
        bus.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        hs_in  = bus.in_valid && bus.in_ready;
        hs_out = bus.out_valid && bus.out_ready;
        if (hs_out) begin
          if (exp_q.size() == 0) begin
            check("rnd_extra_beat", bus.out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check("rnd_data", bus.out_elements, e[31:0]);
            check("rnd_last", bus.out_last, e[32]);
            if (e[32]) tiles_out++;
          end
        end
        if (hs_in) begin
          cur_rows[in_row] = bus.in_elements;
          if (in_row == 0) cur_mode = bus.ctrl;
          beats_in++;
          in_row++;
          if (in_row == 4) begin
            for (int b = 0; b < 4; b++) exp_q.push_back({(b == 3), exp_beat(cur_rows, cur_mode, b)});
            in_row = 0;
          end
        end
        tick();
      end
      check("rnd_tiles_out", tiles_out, 500);
      check("rnd_queue_empty", exp_q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
